// File: rtl/per2axi_res_buffer.sv
// Response buffer between AXI R/B channels and the peripheral response port:
// round-robin R/B arbitration, per-ID lane selection, FIFO storage and TRYX error pulses.
module per2axi_res_buffer #(
    parameter int NB_CORES       = 4,
    parameter int PER_ID_WIDTH   = 9,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    output logic                        per_slave_r_valid_o,
    input  logic                        per_slave_r_ready_i,
    output logic                        per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]     per_slave_r_id_o,
    output logic [31:0]                 per_slave_r_rdata_o,

    output logic [NB_CORES-1:0]         axi_xresp_slverr_o,
    output logic [NB_CORES-1:0]         axi_xresp_valid_o,

    input  logic                        axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data_i,
    input  logic [1:0]                  axi_master_r_resp_i,
    input  logic                        axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_master_r_user_i,
    output logic                        axi_master_r_ready_o,

    input  logic                        axi_master_b_valid_i,
    input  logic [1:0]                  axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_master_b_user_i,
    output logic                        axi_master_b_ready_o,

    input  logic                        trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]     trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   trans_add_i,

    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int LW     = $clog2(AXI_DATA_WIDTH / 32);
    localparam int LW_S   = (LW > 0) ? LW : 1;
    localparam int NB_IDS = 2 ** AXI_ID_WIDTH;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    function automatic logic [PER_ID_WIDTH-1:0] id_onehot(input logic [AXI_ID_WIDTH-1:0] id);
        logic [PER_ID_WIDTH-1:0] oh;
        oh     = {PER_ID_WIDTH{1'b0}};
        oh[id] = 1'b1;
        return oh;
    endfunction

    logic [LW_S-1:0]          lane_s;
    logic [31:0]              lane_data_s;
    logic                     rr_r_prio_r;
    logic                     grant_r_s;
    logic                     grant_b_s;
    logic                     full_s;
    logic                     push_r_s;
    logic                     push_b_s;
    logic                     push_s;
    logic                     pop_s;
    logic [1:0]               push_resp_s;
    logic [AXI_ID_WIDTH-1:0]  push_id_s;
    logic [31:0]              push_data_s;
    logic [NB_CORES-1:0]      tryx_hit_s;
    logic [NB_CORES-1:0]      tryx_r;
    logic [PW-1:0]            wptr_r;
    logic [PW-1:0]            rptr_r;
    logic [CW-1:0]            count_r;
    logic [31:0]              data_mem_r [FIFO_DEPTH];
    logic                     opc_mem_r  [FIFO_DEPTH];
    logic [PER_ID_WIDTH-1:0]  id_mem_r   [FIFO_DEPTH];

    // Lane table remembers which 32-bit word of the bus each outstanding ID targets
    generate
        if (LW > 0) begin : g_lane_tbl
            logic [LW-1:0] lane_tbl_r [NB_IDS];

            // Lane table update on each issued request
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < NB_IDS; i++) begin
                        lane_tbl_r[i] <= {LW{1'b0}};
                    end
                end else if (trans_req_i) begin
                    lane_tbl_r[trans_id_i] <= trans_add_i[LW+1:2];
                end
            end

            assign lane_s = lane_tbl_r[axi_master_r_id_i];
        end else begin : g_no_lane_tbl
            assign lane_s = {LW_S{1'b0}};
        end
    endgenerate

    // Arbitration, handshake and push-entry formation
    always_comb begin
        grant_r_s = 1'b0;
        grant_b_s = 1'b0;
        if (axi_master_r_valid_i && axi_master_b_valid_i) begin
            grant_r_s = rr_r_prio_r;
            grant_b_s = !rr_r_prio_r;
        end else if (axi_master_r_valid_i) begin
            grant_r_s = 1'b1;
        end else if (axi_master_b_valid_i) begin
            grant_b_s = 1'b1;
        end else begin
            grant_r_s = 1'b0;
            grant_b_s = 1'b0;
        end

        full_s               = (count_r == CW'(FIFO_DEPTH));
        axi_master_r_ready_o = grant_r_s && !full_s && rst_ni;
        axi_master_b_ready_o = grant_b_s && !full_s && rst_ni;
        push_r_s             = axi_master_r_ready_o && axi_master_r_valid_i;
        push_b_s             = axi_master_b_ready_o && axi_master_b_valid_i;
        push_s               = push_r_s || push_b_s;
        pop_s                = (count_r != {CW{1'b0}}) && per_slave_r_ready_i;

        lane_data_s = axi_master_r_data_i[32*int'(lane_s) +: 32];
        if (push_r_s) begin
            push_resp_s = axi_master_r_resp_i;
            push_id_s   = axi_master_r_id_i;
            push_data_s = lane_data_s;
        end else begin
            push_resp_s = axi_master_b_resp_i;
            push_id_s   = axi_master_b_id_i;
            push_data_s = 32'h0000_0000;
        end

        // TRYX only reports SLVERR for IDs that map onto a core
        tryx_hit_s = {NB_CORES{1'b0}};
        for (int c = 0; c < NB_CORES; c++) begin
            tryx_hit_s[c] = push_s && (push_resp_s == 2'b10) && (int'(push_id_s) == c);
        end
    end

    // Round-robin pointer and TRYX pulse registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_r_prio_r <= 1'b1;
            tryx_r      <= {NB_CORES{1'b0}};
        end else begin
            if (push_s) begin
                rr_r_prio_r <= !rr_r_prio_r;
            end
            tryx_r <= tryx_hit_s;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                opc_mem_r[i]  <= 1'b0;
                id_mem_r[i]   <= {PER_ID_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                data_mem_r[wptr_r] <= push_data_s;
                opc_mem_r[wptr_r]  <= push_resp_s[1];
                id_mem_r[wptr_r]   <= id_onehot(push_id_s);
                wptr_r             <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign per_slave_r_valid_o = (count_r != {CW{1'b0}});
    assign per_slave_r_opc_o   = opc_mem_r[rptr_r];
    assign per_slave_r_id_o    = id_mem_r[rptr_r];
    assign per_slave_r_rdata_o = data_mem_r[rptr_r];
    assign axi_xresp_slverr_o  = tryx_r;
    assign axi_xresp_valid_o   = tryx_r;
    assign fifo_count_o        = count_r;

    logic unused_s;
    assign unused_s = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i, trans_add_i};

endmodule

// File: tb/tb_per2axi_res_buffer.sv
// Directed self-checking bench for per2axi_res_buffer with default parameters.
module tb_per2axi_res_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_valid;
    logic        per_ready;
    logic        per_opc;
    logic [8:0]  per_id;
    logic [31:0] per_rdata;
    logic [3:0]  x_slverr;
    logic [3:0]  x_valid;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        r_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        b_ready;
    logic        t_req;
    logic [2:0]  t_id;
    logic [31:0] t_add;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    per2axi_res_buffer dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .per_slave_r_valid_o  (per_valid),
        .per_slave_r_ready_i  (per_ready),
        .per_slave_r_opc_o    (per_opc),
        .per_slave_r_id_o     (per_id),
        .per_slave_r_rdata_o  (per_rdata),
        .axi_xresp_slverr_o   (x_slverr),
        .axi_xresp_valid_o    (x_valid),
        .axi_master_r_valid_i (r_valid),
        .axi_master_r_data_i  (r_data),
        .axi_master_r_resp_i  (r_resp),
        .axi_master_r_last_i  (r_last),
        .axi_master_r_id_i    (r_id),
        .axi_master_r_user_i  (r_user),
        .axi_master_r_ready_o (r_ready),
        .axi_master_b_valid_i (b_valid),
        .axi_master_b_resp_i  (b_resp),
        .axi_master_b_id_i    (b_id),
        .axi_master_b_user_i  (b_user),
        .axi_master_b_ready_o (b_ready),
        .trans_req_i          (t_req),
        .trans_id_i           (t_id),
        .trans_add_i          (t_add),
        .fifo_count_o         (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        per_ready = 1'b0;
        r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b1; r_id = 3'd0; r_user = 6'h15;
        b_valid = 1'b0; b_resp = 2'b00; b_id = 3'd0; b_user = 6'h2A;
        t_req = 1'b0; t_id = 3'd0; t_add = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        r_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        tick();
        checks++; if (per_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", per_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if ({r_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {r_ready, b_ready}); end
        checks++; if ({x_slverr, x_valid} !== 8'h00) begin errors++; $display("FAIL reset_xresp got %h want 00", {x_slverr, x_valid}); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_lane();
        do_reset();
        t_req = 1'b1; t_id = 3'd2; t_add = 32'h0000_0104;
        tick();
        t_req = 1'b0;
        r_valid = 1'b1; r_id = 3'd2; r_data = 64'hAABBCCDD_11223344;
        #1;
        checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL lane_r_ready got %b want 1", r_ready); end
        tick();
        r_valid = 1'b0;
        checks++; if ({per_valid, per_opc, per_id, per_rdata} !== {1'b1, 1'b0, 9'h004, 32'hAABBCCDD})
            begin errors++; $display("FAIL lane_hi got v%b o%b id%h d%h want v1 o0 id004 dAABBCCDD", per_valid, per_opc, per_id, per_rdata); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL lane_count got %0d want 1", count); end
        per_ready = 1'b1;
        tick();
        per_ready = 1'b0;
        checks++; if ({per_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL lane_pop got v%b c%0d want v0 c0", per_valid, count); end
        // table rewrite in the same cycle as the beat must not affect that beat
        t_req = 1'b1; t_id = 3'd2; t_add = 32'h0000_0100;
        r_valid = 1'b1;
        tick();
        t_req = 1'b0; r_valid = 1'b0;
        checks++; if (per_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL lane_same_cycle got %h want AABBCCDD", per_rdata); end
        per_ready = 1'b1;
        tick();
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        checks++; if (per_rdata !== 32'h11223344) begin errors++; $display("FAIL lane_lo got %h want 11223344", per_rdata); end
        tick();
        per_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_r;
        do_reset();
        per_ready = 1'b1;
        r_valid = 1'b1; r_id = 3'd0;
        b_valid = 1'b1; b_id = 3'd3;
        for (int k = 0; k < 4; k++) begin
            exp_r = (k % 2 == 0);
            r_data = {32'h0, 32'hC0DE0000 + 32'(k)};
            #1;
            checks++; if ({r_ready, b_ready} !== {exp_r, !exp_r})
                begin errors++; $display("FAIL rr_grant k=%0d got %b want %b", k, {r_ready, b_ready}, {exp_r, !exp_r}); end
            tick();
            checks++; if ({per_id, per_rdata} !== (exp_r ? {9'h001, 32'hC0DE0000 + 32'(k)} : {9'h008, 32'h0}))
                begin errors++; $display("FAIL rr_order k=%0d got id%h d%h", k, per_id, per_rdata); end
        end
        r_valid = 1'b0; b_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rr_count got %0d want 1", count); end
        tick();
        per_ready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        r_valid = 1'b1; r_id = 3'd0;
        for (int k = 0; k < 4; k++) begin
            r_data = 64'h100 + 64'(k);
            tick();
        end
        b_valid = 1'b1;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if ({r_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL full_ready got %b want 00", {r_ready, b_ready}); end
        checks++; if (per_rdata !== 32'h100) begin errors++; $display("FAIL full_head_stable got %h want 100", per_rdata); end
        b_valid = 1'b0;
        per_ready = 1'b1;
        tick();
        per_ready = 1'b0;
        checks++; if ({count, per_rdata} !== {3'd3, 32'h101}) begin errors++; $display("FAIL full_pop got c%0d d%h want c3 d101", count, per_rdata); end
        checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got %b want 1", r_ready); end
        r_valid = 1'b0;
        per_ready = 1'b1;
        tick(); tick(); tick();
        per_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain got %0d want 0", count); end
    endtask

    task automatic test_tryx();
        do_reset();
        per_ready = 1'b1;
        b_valid = 1'b1; b_id = 3'd1; b_resp = 2'b10;
        tick();
        b_valid = 1'b0;
        checks++; if ({x_slverr, x_valid} !== 8'h22) begin errors++; $display("FAIL tryx_pulse got %h want 22", {x_slverr, x_valid}); end
        checks++; if ({per_opc, per_id} !== {1'b1, 9'h002}) begin errors++; $display("FAIL tryx_entry got o%b id%h want o1 id002", per_opc, per_id); end
        tick();
        checks++; if ({x_slverr, x_valid} !== 8'h00) begin errors++; $display("FAIL tryx_one_cycle got %h want 00", {x_slverr, x_valid}); end
        b_valid = 1'b1; b_id = 3'd5;
        tick();
        b_valid = 1'b0;
        checks++; if ({x_slverr, x_valid, per_opc, per_id} !== {8'h00, 1'b1, 9'h020})
            begin errors++; $display("FAIL tryx_id5 got x%h o%b id%h want x00 o1 id020", {x_slverr, x_valid}, per_opc, per_id); end
        r_valid = 1'b1; r_id = 3'd1; r_resp = 2'b11;
        tick();
        r_valid = 1'b0;
        checks++; if ({x_valid, per_opc} !== {4'h0, 1'b1}) begin errors++; $display("FAIL tryx_decerr got x%h o%b want x0 o1", x_valid, per_opc); end
        tick();
        per_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        t_req = 1'b1; t_id = 3'd2; t_add = 32'h0000_0104;
        tick();
        t_req = 1'b0;
        r_valid = 1'b1; r_id = 3'd2; r_data = 64'hAABBCCDD_11223344;
        tick(); tick(); tick();
        r_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
        rst_n = 1'b0;
        r_valid = 1'b1;
        #1;
        checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b want 0", r_ready); end
        tick();
        checks++; if ({per_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL mid_flush got v%b c%0d want v0 c0", per_valid, count); end
        r_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        checks++; if (per_rdata !== 32'h11223344) begin errors++; $display("FAIL mid_lane_cleared got %h want 11223344", per_rdata); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_lane();
        test_back_to_back();
        test_full();
        test_tryx();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
